// File: rtl/ghost_wall_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_wall_scheduler
//  Purpose  : Shares one maze-wall lookup port among NUM_GHOSTS ghosts. On
//             each frame_enable it snapshots all ghost positions, probes the
//             up/down/left/right edge pixel of every ghost in turn, collects
//             the wall bits in a shadow register and publishes them together.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             frame_enable          - one-cycle sweep start strobe
//             ghost_x_all/_y_all    - packed 10-bit ghost positions
//             maze_req/_tile_x/_y   - lookup request and probed tile
//             maze_gnt, maze_rdata  - request accepted, returned wall bit
//             ghost_walls           - per ghost {right,left,down,up} flags
//             walls_valid           - pulse when ghost_walls updates
//             busy                  - sweep in progress
//             sweep_overrun         - pulse when a strobe is dropped
//  Revision : 1.0 - initial release
// ============================================================================
module ghost_wall_scheduler #(
  parameter int NUM_GHOSTS   = 4,
  parameter int TILE_WIDTH   = 17,
  parameter int TILE_HEIGHT  = 15,
  parameter int SPRITE_SIZE  = 16,
  parameter int READ_LATENCY = 1,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_enable,
  input  logic [10*NUM_GHOSTS-1:0] ghost_x_all,
  input  logic [10*NUM_GHOSTS-1:0] ghost_y_all,
  output logic                    maze_req,
  output logic [5:0]              maze_tile_x,
  output logic [5:0]              maze_tile_y,
  input  logic                    maze_gnt,
  input  logic                    maze_rdata,
  output logic [4*NUM_GHOSTS-1:0] ghost_walls,
  output logic                    walls_valid,
  output logic                    busy,
  output logic                    sweep_overrun
);

  localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;

  localparam logic signed [10:0] HALF_SPR = 11'(SPRITE_SIZE / 2);
  localparam logic signed [10:0] FULL_SPR = 11'(SPRITE_SIZE);
  localparam logic signed [10:0] X_LIM    = 11'(X_MAX);
  localparam logic signed [10:0] Y_LIM    = 11'(Y_MAX);
  localparam logic [9:0]         TW       = 10'(TILE_WIDTH);
  localparam logic [9:0]         TH       = 10'(TILE_HEIGHT);
  localparam logic [GW-1:0]      LAST_G   = GW'(NUM_GHOSTS - 1);
  localparam logic [2:0]         LAT      = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [9:0]              snap_x [NUM_GHOSTS];
  logic [9:0]              snap_y [NUM_GHOSTS];
  logic [GW-1:0]           g;
  logic [1:0]              d;
  logic [2:0]              lat_cnt;
  logic [4*NUM_GHOSTS-1:0] shadow;

  logic [9:0]              cur_x, cur_y;
  logic signed [10:0]      base_x, base_y;
  logic signed [10:0]      probe_x, probe_y;
  logic                    probe_in_range;
  logic [5:0]              tile_x, tile_y;
  logic                    last_probe;
  logic [GW+1:0]           shadow_idx;

  logic                    step;
  logic                    step_bit;
  logic                    load_cnt;
  logic                    publish;

  // --------------------------------------------------------------------------
  // Probe geometry for the current (g,d) from the snapshot
  // --------------------------------------------------------------------------
  assign cur_x  = snap_x[g];
  assign cur_y  = snap_y[g];
  assign base_x = {1'b0, cur_x};
  assign base_y = {1'b0, cur_y};

  always_comb begin
    probe_x = base_x;
    probe_y = base_y;
    case (d)
      2'd0: begin probe_x = base_x + HALF_SPR;  probe_y = base_y - 11'sd1;    end
      2'd1: begin probe_x = base_x + HALF_SPR;  probe_y = base_y + FULL_SPR;  end
      2'd2: begin probe_x = base_x - 11'sd1;    probe_y = base_y + HALF_SPR;  end
      default: begin probe_x = base_x + FULL_SPR; probe_y = base_y + HALF_SPR; end
    endcase
  end

  // Negative results show up as the sign bit; in range implies px/py fit 10 bits.
  assign probe_in_range = ~probe_x[10] & ~probe_y[10] &
                          (probe_x <= X_LIM) & (probe_y <= Y_LIM);
  assign tile_x         = 6'(probe_x[9:0] / TW);
  assign tile_y         = 6'(probe_y[9:0] / TH);
  assign last_probe     = (g == LAST_G) && (d == 2'd3);
  assign shadow_idx     = {g, d};
  assign busy           = (state != S_IDLE);

  // --------------------------------------------------------------------------
  // Next-state and combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    maze_req    = 1'b0;
    maze_tile_x = 6'd0;
    maze_tile_y = 6'd0;
    step        = 1'b0;
    step_bit    = 1'b0;
    load_cnt    = 1'b0;
    publish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_enable) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (!probe_in_range) begin
          // Off-screen edges count as walls and skip the lookup entirely.
          step       = 1'b1;
          step_bit   = 1'b1;
          state_next = last_probe ? S_DONE : S_ISSUE;
        end else begin
          maze_req    = 1'b1;
          maze_tile_x = tile_x;
          maze_tile_y = tile_y;
          if (maze_gnt) begin
            load_cnt   = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Counter reaches zero on this edge: read data is valid now.
        if (lat_cnt == 3'd1) begin
          step       = 1'b1;
          step_bit   = maze_rdata;
          state_next = last_probe ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        publish    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      g             <= '0;
      d             <= 2'd0;
      lat_cnt       <= 3'd0;
      shadow        <= '1;
      ghost_walls   <= '1;
      walls_valid   <= 1'b0;
      sweep_overrun <= 1'b0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        snap_x[i] <= 10'd0;
        snap_y[i] <= 10'd0;
      end
    end else begin
      state         <= state_next;
      walls_valid   <= publish;
      sweep_overrun <= frame_enable && (state != S_IDLE);

      if ((state == S_IDLE) && frame_enable) begin
        for (int i = 0; i < NUM_GHOSTS; i++) begin
          snap_x[i] <= ghost_x_all[10*i +: 10];
          snap_y[i] <= ghost_y_all[10*i +: 10];
        end
        g <= '0;
        d <= 2'd0;
      end

      if (load_cnt) begin
        lat_cnt <= LAT;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end

      if (step) begin
        shadow[shadow_idx] <= step_bit;
        d <= d + 2'd1;
        if (d == 2'd3) g <= g + 1'b1;
      end

      if (publish) ghost_walls <= shadow;
    end
  end

endmodule
`default_nettype wire
